// File: rtl/branch_predictor_scheduler.sv
// Arbitrates a single-ported 1-bit branch history table between fetch lookups
// and FIFO-buffered resolve updates, with bounded starvation and hit/miss stats.
module branch_predictor_scheduler #(
  parameter int ADDR_W       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_valid,
  input  logic [ADDR_W-1:0]             lk_addr,
  output logic                          lk_ready,
  output logic                          rsp_valid,
  output logic                          rsp_pred,
  input  logic                          up_valid,
  input  logic [ADDR_W-1:0]             up_addr,
  input  logic                          up_taken,
  input  logic                          up_pred,
  output logic                          up_ready,
  output logic                          tbl_en,
  output logic                          tbl_we,
  output logic [ADDR_W-1:0]             tbl_addr,
  output logic                          tbl_wdata,
  input  logic                          tbl_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } entry_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wdata_q;
  logic              full, empty, lk_ok, grant_lk, grant_up, push, pop;

  assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty = (fifo_level == '0);
  assign lk_ok = lk_valid && (starve_cnt < SC_W'(STARVE_LIMIT));
  assign head  = mem[rd_ptr];

  // A full FIFO outranks lookups so resolve can never be blocked indefinitely.
  assign grant_up = rst && (full || (!empty && !lk_ok));
  assign grant_lk = rst && !full && lk_ok;
  assign pop      = grant_up;

  assign up_ready = rst && !full;
  assign push     = up_valid && up_ready;
  assign lk_ready = grant_lk;
  assign tbl_en   = grant_lk || grant_up;
  assign tbl_we   = grant_up;
  assign rsp_pred = rsp_valid && tbl_rdata;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tbl_addr  = addr_q;
    tbl_wdata = wdata_q;
    if (grant_lk) begin
      tbl_addr = lk_addr;
    end else if (grant_up) begin
      tbl_addr  = head.addr;
      tbl_wdata = head.taken;
    end
  end

  // NOTE: FIFO storage is left unreset; validity is tracked by the level and pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: up_addr, taken: up_taken};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rsp_valid <= grant_lk;
      addr_q    <= tbl_addr;
      wdata_q   <= tbl_wdata;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (grant_up || empty)
        starve_cnt <= '0;
      else if (grant_lk && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (push) begin
        if (up_pred == up_taken) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_scheduler.sv
// Directed bench for branch_predictor_scheduler with a behavioural 1-bit table model.
module tb_branch_predictor_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lk_valid = 1'b0;
  logic [3:0]  lk_addr = '0;
  logic        lk_ready, rsp_valid, rsp_pred;
  logic        up_valid = 1'b0;
  logic [3:0]  up_addr = '0;
  logic        up_taken = 1'b0;
  logic        up_pred = 1'b0;
  logic        up_ready, tbl_en, tbl_we, tbl_wdata;
  logic [3:0]  tbl_addr;
  logic        tbl_rdata = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] hit_count, miss_count;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic tbl_mem [16];

  always #5 clk = ~clk;

  branch_predictor_scheduler dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_pred(rsp_pred),
    .up_valid(up_valid), .up_addr(up_addr), .up_taken(up_taken), .up_pred(up_pred),
    .up_ready(up_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata),
    .fifo_level(fifo_level), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Table model: write at the grant edge, registered read data one cycle later.
  initial for (int i = 0; i < 16; i++) tbl_mem[i] = 1'b0;
  always @(posedge clk) begin
    if (tbl_en && tbl_we) begin
      tbl_mem[tbl_addr] <= tbl_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (tbl_en) begin
      tbl_rdata <= tbl_mem[tbl_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    lk_valid = 1'b0;
    up_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive_up(input logic v, input logic [3:0] a, input logic t, input logic p);
    up_valid = v; up_addr = a; up_taken = t; up_pred = p;
  endtask

  int saved_wr;
  logic exp_lk [6];

  initial begin
    // Reset state
    #2;
    check("rst_up_ready", up_ready, 0);
    check("rst_tbl_en", tbl_en, 0);
    check("rst_level", fifo_level, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("idle_tbl_en", tbl_en, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_level", fifo_level, 0);
    check("idle_up_ready", up_ready, 1);
    check("idle_hit", hit_count, 0);
    check("idle_miss", miss_count, 0);

    // Write-then-read: update addr 1 taken, lookup addr 1 two cycles later
    drive_up(1, 4'd1, 1, 1);
    #1 check("wr_no_grant_empty", tbl_en, 0);
    tick();
    drive_up(0, 4'd0, 0, 0);
    #1;
    check("wr_tbl_we", tbl_we, 1);
    check("wr_tbl_addr", tbl_addr, 1);
    check("wr_tbl_wdata", tbl_wdata, 1);
    tick();
    lk_valid = 1'b1; lk_addr = 4'd1;
    #1;
    check("rd_lk_ready", lk_ready, 1);
    check("rd_tbl_we", tbl_we, 0);
    check("rd_rsp_not_yet", rsp_valid, 0);
    tick();
    lk_valid = 1'b0;
    #1;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_pred", rsp_pred, 1);
    check("rd_hit", hit_count, 1);
    check("idle_addr_hold", tbl_addr, 1);
    tick();
    #1 check("rsp_one_shot", rsp_valid, 0);

    // Starvation guard: one queued update waits exactly STARVE_LIMIT lookups
    do_reset();
    lk_valid = 1'b1; lk_addr = 4'd2;
    drive_up(1, 4'd3, 0, 0);
    #1 check("sv_c0_lk", lk_ready, 1);
    tick();
    drive_up(0, 4'd0, 0, 0);
    exp_lk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("sv_c%0d_lk", i + 1), lk_ready, exp_lk[i]);
      check($sformatf("sv_c%0d_we", i + 1), tbl_we, !exp_lk[i]);
      tick();
    end
    lk_valid = 1'b0;
    #1 check("sv_level_end", fifo_level, 0);

    // FIFO full: four pushes while lookups starve them
    do_reset();
    lk_valid = 1'b1; lk_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      drive_up(1, 4'(8 + i), 1, 1);
      #1 check($sformatf("full_push%0d_lk", i), lk_ready, 1);
      tick();
    end
    drive_up(1, 4'd12, 1, 0);
    #1;
    check("full_level", fifo_level, 4);
    check("full_up_ready", up_ready, 0);
    check("full_lk_ready", lk_ready, 0);
    check("full_tbl_we", tbl_we, 1);
    check("full_tbl_addr", tbl_addr, 8);
    tick();
    drive_up(0, 4'd0, 0, 0);
    #1;
    check("drop_level", fifo_level, 3);
    check("drop_hit", hit_count, 4);
    check("drop_miss", miss_count, 0);
    check("after_full_lk", lk_ready, 1);
    tick();
    lk_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("drain%0d_addr", i), tbl_addr, 9 + i);
      tick();
    end
    #1 check("drain_level", fifo_level, 0);

    // Statistics
    do_reset();
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 1000; k++) begin
        drive_up(1, 4'd1, 1, 1);
        tick();
      end
      drive_up(1, 4'd1, 0, 1);
      tick();
    end
    #1 check("stats_level_steady", fifo_level, 1);
    drive_up(0, 4'd0, 0, 0);
    tick();
    #1;
    check("stats_hit", hit_count, 40000);
    check("stats_miss", miss_count, 40);

    // Async reset mid-traffic
    do_reset();
    lk_valid = 1'b1; lk_addr = 4'd1;
    for (int i = 0; i < 3; i++) begin
      drive_up(1, 4'(4 + i), 1, 1);
      tick();
    end
    drive_up(0, 4'd0, 0, 0);
    lk_valid = 1'b0;
    #1;
    check("ar_level_before", fifo_level, 3);
    check("ar_rsp_before", rsp_valid, 1);
    saved_wr = wr_cnt;
    #1 rst = 1'b0;
    #1;
    check("ar_level_now", fifo_level, 0);
    check("ar_rsp_now", rsp_valid, 0);
    check("ar_tbl_en_now", tbl_en, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    #1;
    check("ar_no_writes", wr_cnt, saved_wr);
    check("ar_level_after", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
